// File: rtl/locked_seq_multiplier.sv
`default_nettype none
// ============================================================================
// locked_seq_multiplier : key-locked shift-add multiplier, one row per cycle
// Revision 1.0
// ============================================================================
module locked_seq_multiplier #(
  parameter int                 WIDTH       = 8,
  parameter int                 KEY_W       = 32,
  parameter logic [KEY_W-1:0]   KEY_CORRECT = 32'hB544B006
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     operand1_i,
  input  logic [WIDTH-1:0]     operand2_i,
  input  logic [KEY_W-1:0]     keyinput,
  input  logic                 key_we_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [KEY_W-1:0]     key_q,    key_d;
  logic [KEY_W-1:0]     err_q,    err_d;
  logic [KEY_W-1:0]     err_rot;
  logic [WIDTH-1:0]     a_q,      a_d;
  logic [WIDTH-1:0]     b_q,      b_d;
  logic [WIDTH-1:0]     addend;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  // Error vector rotates each iteration so bit 0 always holds e[i mod KEY_W].
  generate
    if (KEY_W == 1) begin : g_rot_single
      assign err_rot = err_q;
    end else begin : g_rot_multi
      assign err_rot = {err_q[0], err_q[KEY_W-1:1]};
    end
  endgenerate

  assign addend = err_q[0] ? ~a_q : a_q;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (key_we_i) key_d = keyinput;
        if (start_i) begin
          a_d     = operand1_i;
          b_d     = operand2_i;
          err_d   = key_d ^ KEY_CORRECT;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (b_q[0]) acc_d = acc_q + ({{WIDTH{1'b0}}, addend} << cnt_q);
        b_d   = b_q >> 1;
        err_d = err_rot;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = acc_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      err_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_locked_seq_multiplier.sv
`default_nettype none
// Randomised and directed checks of locked_seq_multiplier against an arithmetic model.
module tb_locked_seq_multiplier;

  localparam logic [31:0] KC = 32'hB544B006;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  operand1_i = '0;
  logic [7:0]  operand2_i = '0;
  logic [31:0] keyinput = '0;
  logic        key_we_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] result_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mdl_key = '0;

  locked_seq_multiplier dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .operand1_i(operand1_i), .operand2_i(operand2_i),
    .keyinput(keyinput), .key_we_i(key_we_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Row i adds A or its 8-bit complement (when e[i] is set), weighted by 2^i.
  function automatic logic [15:0] ref_mult(input int a, input int b, input logic [31:0] key);
    logic [31:0] e;
    int acc;
    e = key ^ KC;
    acc = 0;
    for (int i = 0; i < 8; i++)
      if ((b >> i) & 1) acc += (e[i % 32] ? (255 - a) : a) * (1 << i);
    return acc[15:0];
  endfunction

  task automatic write_key(input logic [31:0] k);
    @(negedge clk_i);
    key_we_i = 1'b1;
    keyinput = k;
    @(posedge clk_i); #1;
    key_we_i = 1'b0;
    keyinput = $urandom;
    mdl_key  = k;
  endtask

  task automatic count_dones(input string tag, input int cycles, input int exp);
    int d = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i); #1;
      if (done_o) d++;
    end
    chk(tag, d, exp);
  endtask

  // Runs one operation; optionally writes key with start and injects ignored inputs mid-RUN.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit wk, input logic [31:0] kv,
                        input int inject_at);
    int n, busy_cnt;
    @(negedge clk_i);
    start_i    = 1'b1;
    operand1_i = a;
    operand2_i = b;
    if (wk) begin
      key_we_i = 1'b1;
      keyinput = kv;
    end
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    key_we_i = 1'b0;
    operand1_i = $urandom;
    operand2_i = $urandom;
    if (wk) mdl_key = kv;
    n = 0;
    busy_cnt = 0;
    while (n < 30) begin
      if (busy_o) busy_cnt++;
      if (done_o) break;
      if (n == inject_at) begin
        @(negedge clk_i);
        start_i = 1'b1; operand1_i = 8'hFF; operand2_i = 8'hFF;
        key_we_i = 1'b1; keyinput = 32'h0;
        @(posedge clk_i); #1;
        start_i = 1'b0; key_we_i = 1'b0;
      end else begin
        @(posedge clk_i); #1;
      end
      n++;
    end
    chk({tag, " latency"}, n, 9);
    chk({tag, " busy"}, busy_cnt, 8);
    chk({tag, " result"}, result_o, exp);
    @(posedge clk_i); #1;
    chk({tag, " done_pulse"}, done_o, 0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [31:0] rk;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset result", result_o, 0);

    // Locked after reset
    run_op("lock_b1", 8'h29, 8'h01, 16'h0029, 0, 0, -1);
    run_op("lock_b2", 8'h29, 8'h02, 16'h01AC, 0, 0, -1);

    // Correct key
    write_key(KC);
    chk("hold_after_keywr", result_o, 16'h01AC);
    run_op("ok_29x7a", 8'h29, 8'h7A, 16'h138A, 0, 0, -1);
    run_op("ok_ffxff", 8'hFF, 8'hFF, 16'hFE01, 0, 0, -1);
    run_op("ok_80x80", 8'h80, 8'h80, 16'h4000, 0, 0, -1);

    // One bit wrong
    write_key(32'hB544B007);
    run_op("bad1_b1", 8'h29, 8'h01, 16'h00D6, 0, 0, -1);
    run_op("bad1_b0", 8'h29, 8'h00, 16'h0000, 0, 0, -1);

    // Ignored start/key write during RUN
    write_key(KC);
    run_op("ign", 8'h29, 8'h7A, 16'h138A, 0, 0, 3);
    count_dones("ign no_extra_done", 12, 0);
    run_op("ign keykept", 8'h29, 8'h02, 16'h0052, 0, 0, -1);

    // Simultaneous start and key write, from zero key
    rst_i = 1'b1; #1;
    @(negedge clk_i); rst_i = 1'b0; mdl_key = 0;
    run_op("simul", 8'h29, 8'h02, 16'h0052, 1, KC, -1);

    // Randomised against the model
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(2, 0))
        0: rk = KC;
        1: rk = KC ^ (32'h1 << $urandom_range(7, 0));
        default: rk = $urandom;
      endcase
      write_key(rk);
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("rand%0d", t), ra, rb, ref_mult(ra, rb, mdl_key), 0, 0, -1);
    end

    // Reset mid-operation
    write_key(KC);
    run_op("pre_rst", 8'h29, 8'h7A, 16'h138A, 0, 0, -1);
    @(negedge clk_i);
    start_i = 1'b1; operand1_i = 8'h29; operand2_i = 8'h7A;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst busy", busy_o, 0);
    chk("midrst done", done_o, 0);
    chk("midrst result", result_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mdl_key = 0;
    count_dones("midrst no_done", 15, 0);
    chk("midrst result_held", result_o, 0);
    write_key(KC);
    run_op("post_rst", 8'h11, 8'h11, 16'h0121, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
